// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte buffer behind the UART receiver.
// Bytes arrive on a one-cycle strobe and leave through a valid/ready handshake.
// Fill level and a sticky overflow flag make dropped characters visible.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_strobe,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow,
    input  logic              clr_overflow
);

    localparam int LEVEL_W = ADDR_W + 1;

    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    level_q, level_d;
    logic               overflow_q, overflow_d;
    logic               push_s, pop_s, drop_s;

    // Outputs are pure decodes of registered state; nothing from in_* or out_ready.
    always_comb begin
        out_valid = (level_q != LEVEL_W'(0));
        full      = (level_q == LEVEL_W'(DEPTH));
        level     = level_q;
        overflow  = overflow_q;
        if (out_valid) begin
            out_data = mem_q[rd_ptr_q];
        end else begin
            out_data = 8'h00;
        end
    end

    // Handshake decode and next-state for pointers, level, storage and overflow.
    always_comb begin
        pop_s      = out_valid & out_ready;
        push_s     = in_strobe & (~full | pop_s);
        drop_s     = in_strobe & full & ~pop_s;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        // When full, a simultaneous pop frees the slot wr_ptr now points at.
        if (push_s) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state with asynchronous reset; stored bytes are discarded via level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are never reset, only invalidated by level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus hand-computed literal expectations at key points.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_strobe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] level;
    logic       full;
    logic       overflow;
    logic       clr_overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];     // reference FIFO contents
    logic       movf;      // reference overflow flag
    logic [7:0] rx[$];     // bytes consumed from the DUT

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_strobe(in_strobe),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .full(full), .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue semantics of the buffer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            movf <= 1'b0;
        end else begin
            bit m_pop, m_full, m_push;
            m_pop  = (mq.size() > 0) && out_ready;
            m_full = (mq.size() == DEPTH);
            m_push = in_strobe && (!m_full || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(in_data);
            if (in_strobe && m_full && !m_pop) movf <= 1'b1;
            else if (clr_overflow) movf <= 1'b0;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [7:0] exp_d;
        exp_d = (mq.size() > 0) ? mq[0] : 8'h00;
        check("m_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("m_level", 32'(level), 32'(mq.size()));
        check("m_full", 32'(full), 32'(mq.size() == DEPTH));
        check("m_ovf", 32'(overflow), 32'(movf));
        check("m_data", 32'(out_data), 32'(exp_d));
    end

    // One cycle of stimulus: drive at negedge, advance to next negedge.
    task automatic cyc(input logic s, input logic [7:0] d, input logic r, input logic c);
        if (r && out_valid) rx.push_back(out_data);
        in_strobe    = s;
        in_data      = d;
        out_ready    = r;
        clr_overflow = c;
        @(negedge clk);
        in_strobe    = 1'b0;
        in_data      = 8'h00;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (!out_valid) break;
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check(name, 32'(out_valid), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_strobe = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));

        // Single byte in and out
        cyc(1'b1, 8'h41, 1'b0, 1'b0);
        check("one_valid", 32'(out_valid), 32'(1));
        check("one_data", 32'(out_data), 32'h41);
        check("one_level", 32'(level), 32'(1));
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("pop_valid", 32'(out_valid), 32'(0));
        check("pop_data", 32'(out_data), 32'(0));
        check("pop_level", 32'(level), 32'(0));

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'(1));
        check("fill_level", 32'(level), 32'(16));
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        check("drop_ovf", 32'(overflow), 32'(1));
        check("drop_level", 32'(level), 32'(16));
        rx.delete();
        drain("drain1_end");
        check("drain1_cnt", 32'(rx.size()), 32'(16));
        for (int i = 0; i < 16 && i < rx.size(); i++) check("drain1_byte", 32'(rx[i]), 32'(i));
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'(0));

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        rx.delete();
        cyc(1'b1, 8'hAA, 1'b1, 1'b0);
        check("fp_level", 32'(level), 32'(16));
        check("fp_ovf", 32'(overflow), 32'(0));
        drain("drain2_end");
        check("drain2_cnt", 32'(rx.size()), 32'(17));
        if (rx.size() == 17) begin
            check("drain2_first", 32'(rx[0]), 32'h10);
            check("drain2_last", 32'(rx[16]), 32'hAA);
        end

        // Wrap-around stream with random consumer gaps
        rx.delete();
        for (int i = 0; i < 40; i++) begin
            logic r;
            r = (level >= 5'd12) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc(1'b1, 8'(8'h80 + i), r, 1'b0);
        end
        drain("drain3_end");
        check("wrap_cnt", 32'(rx.size()), 32'(40));
        for (int i = 0; i < 40 && i < rx.size(); i++) check("wrap_byte", 32'(rx[i]), 32'(8'h80 + i));
        check("wrap_ovf", 32'(overflow), 32'(0));

        // Drop and clear in the same cycle: set wins
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1);
        check("race_ovf", 32'(overflow), 32'(1));
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("race_clr", 32'(overflow), 32'(0));

        // Async reset between edges with five bytes buffered
        for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst_level", 32'(level), 32'(5));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_level", 32'(level), 32'(0));
        check("arst_full", 32'(full), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        check("post_rst_data", 32'(out_data), 32'h55);
        check("post_rst_level", 32'(level), 32'(1));
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
